// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode constants and the decoded ID/EX bundle.
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_AND  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] operand_a;
      logic [XLEN-1:0] operand_b;
      alu_op_e         alu_op;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rd_addr;
      logic            rd_wren;
      logic            illegal;
   } dec_bundle_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101.
   function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// RV32I instruction to ALU op / operand selection decode.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the bundle under its own handshake.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   output dec_bundle_t     o_dec
);

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;

   assign opcode = i_instr[6:0];
   assign rd     = i_instr[11:7];
   assign f3     = i_instr[14:12];
   assign f7     = i_instr[31:25];
   assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
   assign imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign imm_u  = {i_instr[31:12], 12'b0};
   assign shamt  = {27'b0, i_instr[24:20]};

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   alu_op_e         op;
   logic            wren;
   logic            ill;

   always_comb begin
      op_a = '0;
      op_b = '0;
      op   = ALU_ADD;
      wren = 1'b1;
      ill  = 1'b0;
      case (opcode)
         OPC_OP: begin
            op_a = i_rs1_data;
            op_b = i_rs2_data;
            op   = f3_op(f3, f7[5]);
            // funct7=0100000 only names SUB and SRA.
            if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
               ill = 1'b1;
         end
         OPC_OP_IMM: begin
            op_a = i_rs1_data;
            op_b = imm_i;
            op   = f3_op(f3, 1'b0);
            if (f3 == 3'b001) begin
               op_b = shamt;
               if (f7 != F7_BASE) ill = 1'b1;
            end else if (f3 == 3'b101) begin
               op_b = shamt;
               op   = f3_op(f3, f7 == F7_ALT);
               if (f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
            end
         end
         OPC_LUI: begin
            op_b = imm_u;
         end
         OPC_AUIPC: begin
            op_a = i_pc;
            op_b = imm_u;
         end
         OPC_LOAD: begin
            op_a = i_rs1_data;
            op_b = imm_i;
         end
         OPC_STORE: begin
            op_a = i_rs1_data;
            op_b = imm_s;
            wren = 1'b0;
         end
         OPC_JAL, OPC_JALR: begin
            op_a = i_pc;
            op_b = 32'd4;
         end
         OPC_BRANCH: begin
            op_a = i_rs1_data;
            op_b = i_rs2_data;
            op   = ALU_SUB;
            wren = 1'b0;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         op_a = '0;
         op_b = '0;
         op   = ALU_ADD;
      end
   end

   always_comb begin
      o_dec           = '0;
      o_dec.operand_a = op_a;
      o_dec.operand_b = op_b;
      o_dec.alu_op    = op;
      o_dec.rs2_data  = i_rs2_data;
      o_dec.rd_addr   = rd;
      o_dec.rd_wren   = wren && !ill && (rd != 5'd0);
      o_dec.illegal   = ill;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register: decodes an instruction and holds it for the execute-stage ALU.
// Latency: one cycle from accept to o_valid.
// Backpressure: o_ready drops while a held result is not taken; flush beats accept.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int         W        = 32,
   parameter logic [3:0] RESET_OP = 4'b0000
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [31:0]  i_instr,
   input  logic [W-1:0] i_pc,
   input  logic [W-1:0] i_rs1_data,
   input  logic [W-1:0] i_rs2_data,
   input  logic         i_flush,
   input  logic         i_ex_ready,
   output logic         o_valid,
   output logic [W-1:0] o_operand_a,
   output logic [W-1:0] o_operand_b,
   output logic [3:0]   o_alu_op,
   output logic [W-1:0] o_rs2_data,
   output logic [4:0]   o_rd_addr,
   output logic         o_rd_wren,
   output logic         o_illegal
);

   // The bundle is sized by alu_pkg::XLEN; W is expected to match it.
   dec_bundle_t dec;
   dec_bundle_t held;
   logic        vld;
   logic        accept;

   alu_op_decode u_decode (
      .i_instr    (i_instr),
      .i_pc       (i_pc),
      .i_rs1_data (i_rs1_data),
      .i_rs2_data (i_rs2_data),
      .o_dec      (dec)
   );

   assign o_ready = !vld || i_ex_ready;
   assign accept  = i_valid && o_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld         <= 1'b0;
         held        <= '0;
         held.alu_op <= alu_op_e'(RESET_OP);
      end else if (i_flush) begin
         vld <= 1'b0;
      end else if (accept) begin
         vld  <= 1'b1;
         held <= dec;
      end else if (i_ex_ready) begin
         vld <= 1'b0;
      end
   end

   assign o_valid     = vld;
   assign o_operand_a = held.operand_a;
   assign o_operand_b = held.operand_b;
   assign o_alu_op    = held.alu_op;
   assign o_rs2_data  = held.rs2_data;
   assign o_rd_addr   = held.rd_addr;
   assign o_rd_wren   = held.rd_wren;
   assign o_illegal   = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected bundles queued on accept, compared while held.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        flush;
   logic        ex_ready;
   logic        o_valid;
   logic [31:0] o_a;
   logic [31:0] o_b;
   logic [3:0]  o_op;
   logic [31:0] o_rs2;
   logic [4:0]  o_rd;
   logic        o_wren;
   logic        o_ill;

   always #5 clk = ~clk;

   alu_issue_stage #(.W(32), .RESET_OP(4'b0000)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_instr     (instr),
      .i_pc        (pc),
      .i_rs1_data  (rs1),
      .i_rs2_data  (rs2),
      .i_flush     (flush),
      .i_ex_ready  (ex_ready),
      .o_valid     (o_valid),
      .o_operand_a (o_a),
      .o_operand_b (o_b),
      .o_alu_op    (o_op),
      .o_rs2_data  (o_rs2),
      .o_rd_addr   (o_rd),
      .o_rd_wren   (o_wren),
      .o_illegal   (o_ill)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rs2;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        wren;
      logic        ill;
      logic        full;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Compare at the falling edge, then advance the model across the rising edge.
   task automatic tick();
      bit push;
      bit pop;
      @(negedge clk);
      chk("o_ready", 32'(ready), 32'(q.size() == 0 || ex_ready));
      chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("alu_op", 32'(o_op), 32'(q[0].op));
         chk("illegal", 32'(o_ill), 32'(q[0].ill));
         chk("rd_wren", 32'(o_wren), 32'(q[0].wren));
         if (q[0].full) begin
            chk("operand_a", o_a, q[0].a);
            chk("operand_b", o_b, q[0].b);
            chk("rs2_data", o_rs2, q[0].rs2);
         end
         if (q[0].wren) chk("rd_addr", 32'(o_rd), 32'(q[0].rd));
      end
      pop  = (q.size() != 0) && (ex_ready || flush);
      push = valid && (q.size() == 0 || ex_ready) && !flush;
      @(posedge clk);
      #1;
      if (pop)  q.delete(0);
      if (push) q.push_back(cur);
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc_v,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] rd,
                       input logic wr, input logic il, input logic full);
      valid = 1'b1;
      instr = ins;
      pc    = pc_v;
      rs1   = r1;
      rs2   = r2;
      cur   = '{a: a, b: b, rs2: r2, op: op, rd: rd, wren: wr, ill: il, full: full};
      tick();
   endtask

   task automatic idle();
      valid = 1'b0;
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      valid    = 1'b0;
      instr    = '0;
      pc       = '0;
      rs1      = '0;
      rs2      = '0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      #12;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_op", 32'(o_op), 32'd0);
      chk("rst_a", o_a, 32'd0);
      chk("rst_b", o_b, 32'd0);
      chk("rst_wren", 32'(o_wren), 32'd0);
      chk("rst_ill", 32'(o_ill), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ADD x3,x1,x2
      send(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0, 1'b1);
      idle();

      // SRAI back to back with an illegal shift encoding
      send(32'h40415093, 32'h40, 32'hF0000000, 32'h0, 32'hF0000000, 32'd4, 4'd9, 5'd1, 1'b1, 1'b0, 1'b1);
      send(32'h42415093, 32'h44, 32'hF0000000, 32'h0, 32'h0, 32'h0, 4'd0, 5'd1, 1'b0, 1'b1, 1'b0);
      idle();

      // Stall three cycles with a second instruction waiting
      send(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0, 1'b1);
      ex_ready = 1'b0;
      send(32'h40208233, 32'h4, 32'd9, 32'd4, 32'd9, 32'd4, 4'd1, 5'd4, 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      ex_ready = 1'b1;
      tick();
      idle();

      // Flush with a simultaneous accept, then the same LUI accepted
      flush = 1'b1;
      send(32'h123452B7, 32'h8, 32'h0, 32'h0, 32'h0, 32'h12345000, 4'd0, 5'd5, 1'b1, 1'b0, 1'b1);
      flush = 1'b0;
      idle();
      send(32'h123452B7, 32'h8, 32'h0, 32'h0, 32'h0, 32'h12345000, 4'd0, 5'd5, 1'b1, 1'b0, 1'b1);
      idle();

      // Flush kills a held, stalled instruction
      send(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0, 1'b1);
      ex_ready = 1'b0;
      flush    = 1'b1;
      idle();
      flush    = 1'b0;
      ex_ready = 1'b1;
      idle();

      // AUIPC, BEQ, ADDI x0, SW, LW (negative imm), JAL, XOR, bad funct7
      send(32'h00001317, 32'h100, 32'h0, 32'h0, 32'h100, 32'h1000, 4'd0, 5'd6, 1'b1, 1'b0, 1'b1);
      send(32'h00208463, 32'h104, 32'd3, 32'd3, 32'd3, 32'd3, 4'd1, 5'd8, 1'b0, 1'b0, 1'b1);
      send(32'h00000013, 32'h108, 32'h11, 32'h0, 32'h11, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      send(32'h0020A623, 32'h10C, 32'h1000, 32'hCAFE, 32'h1000, 32'd12, 4'd0, 5'd12, 1'b0, 1'b0, 1'b1);
      send(32'hFFC0A383, 32'h110, 32'h2000, 32'h0, 32'h2000, 32'hFFFFFFFC, 4'd0, 5'd7, 1'b1, 1'b0, 1'b1);
      send(32'h008000EF, 32'h114, 32'h0, 32'h0, 32'h114, 32'd4, 4'd0, 5'd1, 1'b1, 1'b0, 1'b1);
      send(32'h0020C2B3, 32'h118, 32'hF0F0, 32'h0FF0, 32'hF0F0, 32'h0FF0, 4'd4, 5'd5, 1'b1, 1'b0, 1'b1);
      send(32'h40209233, 32'h11C, 32'h1, 32'h2, 32'h0, 32'h0, 4'd0, 5'd4, 1'b0, 1'b1, 1'b0);
      idle();

      // Asynchronous reset in the middle of a stall
      send(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0, 1'b1);
      ex_ready = 1'b0;
      valid    = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(o_valid), 32'd0);
      chk("async_op", 32'(o_op), 32'd0);
      chk("async_ready", 32'(ready), 32'd1);
      q.delete();
      tick();
      rst_n    = 1'b1;
      ex_ready = 1'b1;

      // Unknown opcode 0x7F
      send(32'h0000007F, 32'h0, 32'h55, 32'h66, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU interface: decodes an RV32I instruction into the 4-bit ALU op code and selects operand A/B.
- Registers these values in an ID/EX pipeline register with a valid/ready handshake, so the execute stage's combinational ALU consumes them directly.
- Handles stall (back-pressure), flush (bubble insertion) and illegal-instruction flagging.

Parameters:
- W, 32, datapath width of operands and PC.
- RESET_OP, 4'b0000, ALU op code driven while in reset or holding a bubble (ADD).

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream (decode) has an instruction.
- o_ready  output  1  stage can accept an instruction this cycle.
- i_instr  input  32  instruction word.
- i_pc  input  W  PC of i_instr.
- i_rs1_data  input  W  register-file read data for rs1.
- i_rs2_data  input  W  register-file read data for rs2.
- i_flush  input  1  kill the held instruction and any instruction accepted this cycle.
- i_ex_ready  input  1  execute stage accepts the output this cycle.
- o_valid  output  1  output register holds a live instruction.
- o_operand_a  output  W  ALU operand A.
- o_operand_b  output  W  ALU operand B.
- o_alu_op  output  4  ALU op code.
- o_rs2_data  output  W  rs2 passthrough, used as store data.
- o_rd_addr  output  5  destination register.
- o_rd_wren  output  1  writeback enable.
- o_illegal  output  1  unsupported or illegal encoding.

Behaviour:
- ALU op codes: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9. Codes 10-15 are never emitted.
- Reset (async, i_rst_n=0): all outputs registered to 0, o_alu_op=RESET_OP, o_valid=0. Release is sampled on the next rising edge.
- o_ready = !o_valid || i_ex_ready (combinational, no dependence on i_valid). Accept = i_valid && o_ready.
- Latency: 1 cycle from accept to o_valid=1.
- Hold: while o_valid && !i_ex_ready, all outputs stay stable.
- Priority at each edge, highest first:
  - i_flush → o_valid<=0, payload unchanged.
  - accept → load new payload, o_valid<=1.
  - i_ex_ready → o_valid<=0.
  - otherwise hold.
- Decode by opcode (imm_i/imm_s/imm_u sign-extended per ISA):
  - OP 0110011: a=rs1, b=rs2. funct3/funct7 map as follows; any other funct7 → illegal.
    - 000/0000000 ADD; 000/0100000 SUB
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR
    - 101/0000000 SRL; 101/0100000 SRA
    - 110 OR; 111 AND
  - OP-IMM 0010011: a=rs1, b=imm_i. 000 is always ADD (no SUB).
    - Shifts: b={27'b0,shamt}. imm[11:5] must be 0000000 (SLLI/SRLI) or 0100000 (SRAI only); otherwise illegal.
  - LUI 0110111: a=0, b=imm_u, ADD.
  - AUIPC 0010111: a=pc, b=imm_u, ADD.
  - LOAD 0000011: a=rs1, b=imm_i, ADD.
  - STORE 0100011: a=rs1, b=imm_s, ADD, rd_wren=0.
  - JAL 1101111 / JALR 1100111: a=pc, b=4, ADD (link value).
  - BRANCH 1100011: a=rs1, b=rs2, SUB, rd_wren=0.
  - Anything else: o_illegal=1, ADD, a=b=0, rd_wren=0.
- o_rd_wren is forced to 0 when rd==0 and when o_illegal=1.
- Flush and accept in the same cycle: the new instruction is discarded.
- Reset asserted mid-stall clears o_valid immediately, independent of the clock.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum holding the 10 codes above;
  - opcode localparams;
  - decoded-bundle struct {operand_a, operand_b, alu_op, rs2_data, rd_addr, rd_wren, illegal}.
- One combinational sub-module, alu_op_decode: i_instr, i_pc, rs1/rs2 data in, bundle out.
- The top holds the handshake register and flush logic.

Test Plan:
- Reset then i_valid=1, ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, i_ex_ready=1 → next cycle o_valid=1, a=5, b=7, op=0, rd=3, wren=1.
- SRAI x1,x2,4 (0x40415093), rs1=0xF0000000 → op=9, b=4. With imm[11:5]=0100001 → o_illegal=1, wren=0.
- i_ex_ready=0 for 3 cycles while o_valid=1 → o_ready=0, outputs frozen, a second i_valid is not accepted. i_ex_ready=1 → second instruction appears the following cycle.
- i_flush with a simultaneous accept of LUI x5,0x12345 → o_valid=0 next cycle. Next LUI accepted → a=0, b=0x12345000, op=0.
- AUIPC at pc=0x100 imm 1 → a=0x100, b=0x1000. BEQ → op=1, wren=0. ADDI x0,x0,0 → wren=0.
- Assert i_rst_n=0 asynchronously mid-stall → o_valid=0, o_alu_op=0 before the next edge. Opcode 0x7F → o_illegal=1.
